// File: rtl/pong_serve_ctrl.sv
`default_nettype none
// ============================================================================
// pong_serve_ctrl : score keeping, serve countdown and match-end control that
//                   sits downstream of the Pong game FSM and feeds it back.
// Revision        : 1.0 - initial release
// ============================================================================
module pong_serve_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 60,
  parameter logic [9:0]  CENTER_X    = 10'd512,
  parameter logic [9:0]  CENTER_Y    = 10'd512,
  parameter logic [9:0]  PADDLE_HOME = 10'd512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       point_1,
  input  logic       point_2,
  output logic       start,
  output logic       gameover,
  output logic       serve_valid,
  output logic [9:0] x_pos_init,
  output logic [9:0] y_pos_init,
  output logic [9:0] p1_pos_init,
  output logic [9:0] p2_pos_init,
  output logic       v_u_init,
  output logic       v_r_init,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SERVE = 3'b010,
    ST_PLAY  = 3'b100,
    ST_POINT = 3'b011,
    ST_OVER  = 3'b111
  } state_t;

  localparam logic [7:0] c_delay = 8'(SERVE_DELAY);
  localparam logic [3:0] c_win   = 4'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       btn_q, pt1_q, pt2_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_1_q, score_1_d;
  logic [3:0] score_2_q, score_2_d;
  logic [1:0] winner_q, winner_d;
  logic       v_u_q, v_u_d;
  logic       v_r_q, v_r_d;
  logic       start_q, start_d;

  logic btn_rise, pt1_rise, pt2_rise;

  // Edge history is tracked in every state; only the consuming state acts on a rise
  assign btn_rise = btn_start & ~btn_q;
  assign pt1_rise = point_1 & ~pt1_q;
  assign pt2_rise = point_2 & ~pt2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      btn_q     <= 1'b0;
      pt1_q     <= 1'b0;
      pt2_q     <= 1'b0;
      cnt_q     <= 8'd0;
      score_1_q <= 4'd0;
      score_2_q <= 4'd0;
      winner_q  <= 2'b00;
      v_u_q     <= 1'b1;
      v_r_q     <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_start;
      pt1_q     <= point_1;
      pt2_q     <= point_2;
      cnt_q     <= cnt_d;
      score_1_q <= score_1_d;
      score_2_q <= score_2_d;
      winner_q  <= winner_d;
      v_u_q     <= v_u_d;
      v_r_q     <= v_r_d;
      start_q   <= start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    winner_d  = winner_q;
    v_u_d     = v_u_q;
    v_r_d     = v_r_q;
    start_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        score_1_d = 4'd0;
        score_2_d = 4'd0;
        winner_d  = 2'b00;
        if (btn_rise) begin
          state_d = ST_SERVE;
          cnt_d   = c_delay;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_PLAY;
            start_d = 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (pt1_rise && pt2_rise) begin
          // Simultaneous points replay the serve with a flipped vertical direction
          v_u_d   = ~v_u_q;
          state_d = ST_SERVE;
          cnt_d   = c_delay;
        end else if (pt1_rise) begin
          score_1_d = score_1_q + 4'd1;
          v_r_d     = 1'b1;
          v_u_d     = ~v_u_q;
          state_d   = ST_POINT;
        end else if (pt2_rise) begin
          score_2_d = score_2_q + 4'd1;
          v_r_d     = 1'b0;
          v_u_d     = ~v_u_q;
          state_d   = ST_POINT;
        end
      end

      ST_POINT: begin
        if (score_1_q == c_win) begin
          winner_d = 2'b01;
          state_d  = ST_OVER;
        end else if (score_2_q == c_win) begin
          winner_d = 2'b10;
          state_d  = ST_OVER;
        end else begin
          state_d = ST_SERVE;
          cnt_d   = c_delay;
        end
      end

      ST_OVER: begin
        if (btn_rise) begin
          state_d   = ST_IDLE;
          score_1_d = 4'd0;
          score_2_d = 4'd0;
          winner_d  = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign start       = start_q;
  assign gameover    = (state_q == ST_OVER);
  assign serve_valid = (state_q == ST_SERVE);
  assign x_pos_init  = CENTER_X;
  assign y_pos_init  = CENTER_Y;
  assign p1_pos_init = PADDLE_HOME;
  assign p2_pos_init = PADDLE_HOME;
  assign v_u_init    = v_u_q;
  assign v_r_init    = v_r_q;
  assign score_1     = score_1_q;
  assign score_2     = score_2_q;
  assign winner      = winner_q;
  assign state_out   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_serve_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pong_serve_ctrl : directed table, corner sequences and random stimulus
//                      for pong_serve_ctrl (WIN_SCORE=3, SERVE_DELAY=3).
// Revision           : 1.0 - initial release
// ============================================================================
module tb_pong_serve_ctrl;

  localparam int W  = 3;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       point_1 = 1'b0;
  logic       point_2 = 1'b0;
  logic       start, gameover, serve_valid, v_u_init, v_r_init;
  logic [9:0] x_pos_init, y_pos_init, p1_pos_init, p2_pos_init;
  logic [3:0] score_1, score_2;
  logic [1:0] winner;
  logic [2:0] state_out;

  pong_serve_ctrl #(
    .WIN_SCORE   (W),
    .SERVE_DELAY (SD),
    .CENTER_X    (10'd300),
    .CENTER_Y    (10'd200),
    .PADDLE_HOME (10'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .btn_start   (btn_start),
    .point_1     (point_1),
    .point_2     (point_2),
    .start       (start),
    .gameover    (gameover),
    .serve_valid (serve_valid),
    .x_pos_init  (x_pos_init),
    .y_pos_init  (y_pos_init),
    .p1_pos_init (p1_pos_init),
    .p2_pos_init (p2_pos_init),
    .v_u_init    (v_u_init),
    .v_r_init    (v_r_init),
    .score_1     (score_1),
    .score_2     (score_2),
    .winner      (winner),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: match phase, ticks still to wait, plain integer scores
  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_OVER = 4;
  int m_phase, m_left, m_s1, m_s2, m_win;
  bit m_up, m_right, m_start, m_lb, m_l1, m_l2;

  function automatic logic [2:0] phase_code(int ph);
    case (ph)
      PH_IDLE:  return 3'b001;
      PH_SERVE: return 3'b010;
      PH_PLAY:  return 3'b100;
      PH_POINT: return 3'b011;
      default:  return 3'b111;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_up = 1; m_right = 1; m_start = 0; m_lb = 0; m_l1 = 0; m_l2 = 0;
  endtask

  task automatic model_step(input bit r, input bit t, input bit b, input bit a, input bit c);
    bit rb, r1, r2;
    if (r) begin
      model_reset();
      return;
    end
    rb = b && !m_lb; r1 = a && !m_l1; r2 = c && !m_l2;
    m_lb = b; m_l1 = a; m_l2 = c;
    m_start = 0;
    if (m_phase == PH_IDLE) begin
      m_s1 = 0; m_s2 = 0; m_win = 0;
      if (rb) begin m_phase = PH_SERVE; m_left = SD; end
    end else if (m_phase == PH_SERVE) begin
      if (t) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = PH_PLAY; m_start = 1; end
      end
    end else if (m_phase == PH_PLAY) begin
      if (r1 || r2) begin
        m_up = !m_up;
        if (r1 && r2) begin
          m_phase = PH_SERVE; m_left = SD;
        end else begin
          if (r1) m_s1 = m_s1 + 1; else m_s2 = m_s2 + 1;
          m_right = r1;
          m_phase = PH_POINT;
        end
      end
    end else if (m_phase == PH_POINT) begin
      if (m_s1 == W || m_s2 == W) begin
        m_win = (m_s1 == W) ? 1 : 2;
        m_phase = PH_OVER;
      end else begin
        m_phase = PH_SERVE; m_left = SD;
      end
    end else begin
      if (rb) begin m_phase = PH_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic apply(input bit r, input bit t, input bit b, input bit a, input bit c);
    @(negedge clk);
    rst = r; frame_tick = t; btn_start = b; point_1 = a; point_2 = c;
    @(posedge clk);
    model_step(r, t, b, a, c);
    #1;
    chk("m_state",  32'(state_out),   32'(phase_code(m_phase)));
    chk("m_start",  32'(start),       32'(m_start));
    chk("m_sv",     32'(serve_valid), 32'(m_phase == PH_SERVE));
    chk("m_go",     32'(gameover),    32'(m_phase == PH_OVER));
    chk("m_score1", 32'(score_1),     32'(m_s1));
    chk("m_score2", 32'(score_2),     32'(m_s2));
    chk("m_winner", 32'(winner),      32'(m_win));
    chk("m_vu",     32'(v_u_init),    32'(m_up));
    chk("m_vr",     32'(v_r_init),    32'(m_right));
  endtask

  task automatic serve_to_play();
    int n = 0;
    while (m_phase != PH_PLAY && n < 20) begin
      apply(0, 1, 0, 0, 0);
      n++;
    end
    chk("reach_play", 32'(state_out), 32'(3'b100));
  endtask

  typedef struct {
    logic [4:0] in;      // {rst, tick, btn, p1, p2}
    logic [2:0] st;
    logic       stt;
    logic       sv;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       vu;
    logic       vr;
    logic [1:0] win;
    logic       go;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic [4:0] in, logic [2:0] st, logic stt, logic sv,
                              logic [3:0] s1, logic [3:0] s2, logic vu, logic vr,
                              logic [1:0] win, logic go);
    vec_t v;
    v.in = in; v.st = st; v.stt = stt; v.sv = sv; v.s1 = s1; v.s2 = s2;
    v.vu = vu; v.vr = vr; v.win = win; v.go = go;
    return v;
  endfunction

  initial begin
    bit rr, tt, bb, aa, cc;
    model_reset();

    vecs[0]  = mk(5'b10000, 3'b001, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[1]  = mk(5'b00000, 3'b001, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[2]  = mk(5'b01100, 3'b010, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[3]  = mk(5'b01100, 3'b010, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[4]  = mk(5'b00000, 3'b010, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[5]  = mk(5'b01000, 3'b010, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[6]  = mk(5'b01000, 3'b100, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[7]  = mk(5'b00000, 3'b100, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[8]  = mk(5'b00010, 3'b011, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[9]  = mk(5'b00010, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[10] = mk(5'b00011, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[11] = mk(5'b01000, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[12] = mk(5'b01000, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[13] = mk(5'b01000, 3'b100, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    vecs[14] = mk(5'b00011, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[15] = mk(5'b01000, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[16] = mk(5'b01000, 3'b010, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[17] = mk(5'b01000, 3'b100, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    vecs[18] = mk(5'b00001, 3'b011, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 2'd0, 1'b0);
    vecs[19] = mk(5'b00000, 3'b010, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
      chk($sformatf("v%0d_state", i), 32'(state_out),   32'(vecs[i].st));
      chk($sformatf("v%0d_start", i), 32'(start),       32'(vecs[i].stt));
      chk($sformatf("v%0d_sv", i),    32'(serve_valid), 32'(vecs[i].sv));
      chk($sformatf("v%0d_s1", i),    32'(score_1),     32'(vecs[i].s1));
      chk($sformatf("v%0d_s2", i),    32'(score_2),     32'(vecs[i].s2));
      chk($sformatf("v%0d_vu", i),    32'(v_u_init),    32'(vecs[i].vu));
      chk($sformatf("v%0d_vr", i),    32'(v_r_init),    32'(vecs[i].vr));
      chk($sformatf("v%0d_win", i),   32'(winner),      32'(vecs[i].win));
      chk($sformatf("v%0d_go", i),    32'(gameover),    32'(vecs[i].go));
    end

    chk("x_pos_init",  32'(x_pos_init),  32'(300));
    chk("y_pos_init",  32'(y_pos_init),  32'(200));
    chk("p1_pos_init", 32'(p1_pos_init), 32'(100));
    chk("p2_pos_init", 32'(p2_pos_init), 32'(100));

    // Held point counts once
    serve_to_play();
    apply(0, 0, 0, 1, 0);
    chk("held_point_state", 32'(state_out), 32'(3'b011));
    chk("held_point_s1",    32'(score_1),   32'(2));
    apply(0, 0, 0, 1, 0);
    chk("held_serve_state", 32'(state_out), 32'(3'b010));
    for (int i = 0; i < 18; i++) apply(0, 0, 0, 1, 0);
    chk("held_s1_final", 32'(score_1), 32'(2));
    apply(0, 0, 0, 0, 0);

    // Player 2 reaches WIN_SCORE
    serve_to_play();
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0);
    chk("p2_second_s2", 32'(score_2), 32'(2));
    serve_to_play();
    apply(0, 0, 0, 0, 1);
    chk("win_point_state", 32'(state_out), 32'(3'b011));
    chk("win_point_s2",    32'(score_2),   32'(3));
    chk("win_point_go",    32'(gameover),  32'(0));
    apply(0, 0, 0, 0, 0);
    chk("over_state",  32'(state_out), 32'(3'b111));
    chk("over_winner", 32'(winner),    32'(2'b10));
    chk("over_go",     32'(gameover),  32'(1));
    apply(0, 0, 0, 1, 0);
    apply(0, 1, 0, 1, 0);
    chk("over_ignore_s1",  32'(score_1),   32'(2));
    chk("over_hold_state", 32'(state_out), 32'(3'b111));
    apply(0, 0, 1, 0, 0);
    chk("restart_state", 32'(state_out), 32'(3'b001));
    chk("restart_s1",    32'(score_1),   32'(0));
    chk("restart_s2",    32'(score_2),   32'(0));
    chk("restart_win",   32'(winner),    32'(0));
    chk("restart_go",    32'(gameover),  32'(0));
    apply(0, 0, 0, 0, 0);

    // Reset mid-countdown with two ticks still to go
    apply(0, 0, 1, 0, 0);
    apply(0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    chk("rst_state", 32'(state_out),   32'(3'b001));
    chk("rst_sv",    32'(serve_valid), 32'(0));
    chk("rst_s1",    32'(score_1),     32'(0));
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 0, 0, 0);
      chk("rst_no_start", 32'(start),     32'(0));
      chk("rst_idle",     32'(state_out), 32'(3'b001));
    end

    // Random traffic against the model
    rr = 0; tt = 0; bb = 0; aa = 0; cc = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      tt = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) bb = !bb;
      if ($urandom_range(0, 11) == 0) aa = !aa;
      if ($urandom_range(0, 11) == 0) cc = !cc;
      if ($urandom_range(0, 49) == 0) begin
        aa = !(aa || cc); cc = aa;
      end
      apply(rr, tt, bb, aa, cc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
